// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: parameterised coin/selection vending controller
//   Macro VEND_STOCK_EN enables per-drink stock counters, sold_out and refill.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     coin_valid/value    coin insertion
//     sel_valid/sel_id    drink selection
//     cancel              refund request (CREDIT only)
//     refill              reload all stock (IDLE only, stock build)
//     credit              current credit
//     drink_out           one-hot dispense pulse
//     change/change_valid refund amount and its one-cycle strobe
//     coin_reject         one-cycle pulse for a dropped coin
//     sold_out            per-drink empty flags
//     busy                high in VEND and CHANGE
module vending_ctrl_param #(
    parameter int N_DRINKS = 4,
    parameter int MONEY_W = 8,
    parameter logic [N_DRINKS*MONEY_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 5,
    localparam int SEL_W = $clog2(N_DRINKS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [MONEY_W-1:0]  coin_value,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                refill,
    output logic [MONEY_W-1:0]  credit,
    output logic [N_DRINKS-1:0] drink_out,
    output logic [MONEY_W-1:0]  change,
    output logic                change_valid,
    output logic                coin_reject,
    output logic [N_DRINKS-1:0] sold_out,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    state_t r_state;
    logic [MONEY_W-1:0] r_credit, r_change, w_price;
    logic [N_DRINKS-1:0] r_drink, w_sel_oh;
    logic r_change_valid, r_coin_reject, r_busy;
    logic [MONEY_W:0] w_sum;
    logic w_in_range, w_avail, w_cancel, w_buy, w_coin_ok;
    // extra carry bit detects overflow so a coin never wraps the credit
    assign w_sum = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_in_range = {1'b0, sel_id} < (SEL_W+1)'(N_DRINKS);
    always_comb begin
        w_price = '0;
        w_sel_oh = '0;
        for (int i = 0; i < N_DRINKS; i++)
            if (sel_id == SEL_W'(i)) begin
                w_price = PRICES[i*MONEY_W +: MONEY_W];
                w_sel_oh[i] = 1'b1;
            end
    end
`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] r_stock [N_DRINKS];
    logic [N_DRINKS-1:0] r_sold_out;
    assign w_avail = |(w_sel_oh & ~r_sold_out);
    assign sold_out = r_sold_out;
    // sold_out is kept as a register mirroring stock==0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || (r_state == IDLE && refill)) begin
            for (int i = 0; i < N_DRINKS; i++)
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            r_sold_out <= {N_DRINKS{STOCK_INIT == 0}};
        end else if (r_state == VEND) begin
            for (int i = 0; i < N_DRINKS; i++)
                if (r_drink[i]) begin
                    r_stock[i] <= r_stock[i] - 1'b1;
                    r_sold_out[i] <= r_stock[i] == STOCK_W'(1);
                end
        end
`else
    logic w_unused;
    assign w_unused = refill;
    assign w_avail = 1'b1;
    assign sold_out = '0;
`endif
    // priority: cancel > selection > coin; a lower request in the same cycle is dropped
    assign w_cancel = cancel && r_state == CREDIT;
    assign w_buy = !cancel && sel_valid && r_state == CREDIT && w_in_range && r_credit >= w_price && w_avail;
    assign w_coin_ok = coin_valid && !cancel && !sel_valid && (r_state == IDLE || r_state == CREDIT) && !w_sum[MONEY_W];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_change_valid <= 1'b0;
            r_drink <= '0;
            r_coin_reject <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_drink <= '0;
            r_change <= '0;
            r_change_valid <= 1'b0;
            r_coin_reject <= coin_valid && !w_coin_ok;
            case (r_state)
                IDLE, CREDIT:
                    if (w_cancel) begin
                        r_state <= CHANGE;
                        r_change <= r_credit;
                        r_change_valid <= 1'b1;
                        r_credit <= '0;
                        r_busy <= 1'b1;
                    end else if (w_buy) begin
                        r_state <= VEND;
                        r_credit <= r_credit - w_price;
                        r_drink <= w_sel_oh;
                        r_busy <= 1'b1;
                    end else if (w_coin_ok) begin
                        r_credit <= w_sum[MONEY_W-1:0];
                        r_state <= (w_sum[MONEY_W-1:0] != '0) ? CREDIT : r_state;
                    end
                VEND: begin
                    r_state <= CHANGE;
                    r_change <= r_credit;
                    r_change_valid <= 1'b1;
                    r_credit <= '0;
                end
                CHANGE: begin
                    r_state <= IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    assign credit = r_credit;
    assign drink_out = r_drink;
    assign change = r_change;
    assign change_valid = r_change_valid;
    assign coin_reject = r_coin_reject;
    assign busy = r_busy;
endmodule

// File: tb/tb_vending_ctrl_param.sv
// tb_vending_ctrl_param: directed scoreboard bench for vending_ctrl_param
module tb_vending_ctrl_param;
`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, refill = 1'b0;
    logic [7:0] coin_value = '0;
    logic [1:0] sel_id = '0;
    logic [7:0] credit, change;
    logic [3:0] drink_out, sold_out;
    logic change_valid, coin_reject, busy;
    int checks = 0, errors = 0;
    typedef struct {
        logic [3:0] drink;
        logic [7:0] change;
    } exp_t;
    exp_t q[$];

    vending_ctrl_param dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .refill(refill),
        .credit(credit), .drink_out(drink_out), .change(change), .change_valid(change_valid),
        .coin_reject(coin_reject), .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit cv, input logic [7:0] cval, input bit sv, input logic [1:0] id, input bit can, input bit rf);
        coin_valid = cv;
        coin_value = cval;
        sel_valid = sv;
        sel_id = id;
        cancel = can;
        refill = rf;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        sel_valid = 1'b0;
        cancel = 1'b0;
        refill = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        step(1'b1, v, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [3:0] d, input logic [7:0] c);
        exp_t e;
        e.drink = d;
        e.change = c;
        q.push_back(e);
    endtask

    // watch for the dispense pulse and change strobe, compare against the queue head
    task automatic drain(input string tag);
        exp_t e;
        logic [3:0] seen;
        int pulses;
        bit done;
        e = q.pop_front();
        seen = '0;
        pulses = 0;
        done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            if (drink_out != '0) begin
                seen |= drink_out;
                pulses++;
            end
            if (change_valid) begin
                done = 1'b1;
                check({tag, ":change"}, 32'(change), 32'(e.change));
                check({tag, ":credit_cleared"}, 32'(credit), 32'd0);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, ":change_seen"}, 32'(done), 32'd1);
        check({tag, ":drink"}, 32'(seen), 32'(e.drink));
        check({tag, ":pulses"}, pulses, (e.drink != '0) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        check({tag, ":change_zero"}, 32'(change), 32'd0);
    endtask

    initial begin
        #3;
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_drink", 32'(drink_out), 32'd0);
        check("rst_cv", 32'(change_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rej", 32'(coin_reject), 32'd0);
        check("rst_sold", 32'(sold_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // 10 + 5, buy drink 1 (15): no change
        coin(8'd10);
        check("c10_credit", 32'(credit), 32'd10);
        coin(8'd5);
        check("c15_credit", 32'(credit), 32'd15);
        push(4'b0010, 8'd0);
        step(1'b0, 8'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        check("vend1_busy", 32'(busy), 32'd1);
        check("vend1_credit", 32'(credit), 32'd0);
        drain("vend1");
        // 20 + 10, buy drink 0 (10): change 20
        coin(8'd20);
        coin(8'd10);
        push(4'b0001, 8'd20);
        step(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        drain("vend0");
        // overflow coin rejected, credit unchanged
        coin(8'd250);
        coin(8'd10);
        check("ovf_rej", 32'(coin_reject), 32'd1);
        check("ovf_credit", 32'(credit), 32'd250);
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("ovf_rej_pulse", 32'(coin_reject), 32'd0);
        push(4'b1000, 8'd225);
        step(1'b0, 8'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        drain("vend3");
        // cancel refunds without a drink
        coin(8'd15);
        push(4'b0000, 8'd15);
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        drain("cancel");
        // cancel beats a simultaneous valid selection
        coin(8'd15);
        push(4'b0000, 8'd15);
        step(1'b0, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0);
        drain("cancel_sel");
        // insufficient credit: selection ignored
        coin(8'd10);
        step(1'b0, 8'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        check("poor_drink", 32'(drink_out), 32'd0);
        check("poor_busy", 32'(busy), 32'd0);
        check("poor_credit", 32'(credit), 32'd10);
        push(4'b0000, 8'd10);
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        drain("poor_refund");
        // coin dropped when a selection arrives in the same cycle
        coin(8'd5);
        step(1'b1, 8'd5, 1'b1, 2'd0, 1'b0, 1'b0);
        check("prio_rej", 32'(coin_reject), 32'd1);
        check("prio_credit", 32'(credit), 32'd5);
        push(4'b0000, 8'd5);
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        drain("prio_refund");
        // coin during VEND rejected
        coin(8'd20);
        step(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("vcoin_drink", 32'(drink_out), 32'd1);
        coin(8'd5);
        check("vcoin_rej", 32'(coin_reject), 32'd1);
        check("vcoin_cv", 32'(change_valid), 32'd1);
        check("vcoin_change", 32'(change), 32'd10);
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("vcoin_credit", 32'(credit), 32'd0);
        // cancel in IDLE ignored
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        check("idle_cancel_cv", 32'(change_valid), 32'd0);
        check("idle_cancel_busy", 32'(busy), 32'd0);
        // reset mid-VEND
        coin(8'd10);
        step(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("mid_drink_pre", 32'(drink_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_drink", 32'(drink_out), 32'd0);
        check("mid_credit", 32'(credit), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_after_cv", 32'(change_valid), 32'd0);
        check("mid_after_busy", 32'(busy), 32'd0);
        // drain stock of drink 3
        for (int i = 0; i < 6; i++) begin
            coin(8'd25);
            if (i < 5 || !STOCK_EN) begin
                push(4'b1000, 8'd0);
                step(1'b0, 8'd0, 1'b1, 2'd3, 1'b0, 1'b0);
                drain($sformatf("stock%0d", i));
            end else begin
                check("sold_flag", 32'(sold_out), 32'b1000);
                step(1'b0, 8'd0, 1'b1, 2'd3, 1'b0, 1'b0);
                check("sold_drink", 32'(drink_out), 32'd0);
                check("sold_busy", 32'(busy), 32'd0);
                check("sold_credit", 32'(credit), 32'd25);
                push(4'b0000, 8'd25);
                step(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
                drain("sold_refund");
            end
        end
        step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        check("refill_sold", 32'(sold_out), 32'd0);
        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vending_ctrl_param.md
VENDING_CTRL_PARAM -- requirements
Module: vending_ctrl_param

Interface
REQ-001 SHALL have parameter N_DRINKS, default 4: number of products, range 2..8.
REQ-002 SHALL have parameter MONEY_W, default 8: width of money, credit and change.
REQ-003 SHALL have parameter PRICES, default {8'd25,8'd20,8'd15,8'd10}: packed prices; drink i price at [i*MONEY_W +: MONEY_W]; each price nonzero.
REQ-004 SHALL have parameter STOCK_W, default 4: per-drink stock counter width.
REQ-005 SHALL have parameter STOCK_INIT, default 5: stock loaded at reset and on refill.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 coin_valid  input  1  coin_value is valid this cycle.
REQ-010 coin_value  input  MONEY_W  inserted amount.
REQ-011 sel_valid  input  1  selection request this cycle.
REQ-012 sel_id  input  SEL_W=$clog2(N_DRINKS)  drink index.
REQ-013 cancel  input  1  synchronous refund request.
REQ-014 refill  input  1  reload all stock (stock build only).
REQ-015 credit  output  MONEY_W  current credit, registered.
REQ-016 drink_out  output  N_DRINKS  one-hot dispense pulse.
REQ-017 change  output  MONEY_W  refund amount, valid with change_valid.
REQ-018 change_valid  output  1  one-cycle change pulse.
REQ-019 coin_reject  output  1  one-cycle pulse: coin not accepted.
REQ-020 sold_out  output  N_DRINKS  bit i high when drink i stock is 0.
REQ-021 busy  output  1  high in VEND and CHANGE.

Function
REQ-022 SHALL implement FSM IDLE, CREDIT, VEND, CHANGE; all outputs registered.
REQ-023 Input priority per cycle SHALL be cancel > sel_valid > coin_valid; a dropped coin SHALL pulse coin_reject next cycle.
REQ-024 Coin in IDLE/CREDIT: credit += coin_value; IDLE->CREDIT when resulting credit nonzero.
REQ-025 Coin whose sum exceeds 2^MONEY_W-1 SHALL be rejected (coin_reject pulse, credit unchanged); no wrap-around.
REQ-026 Coins in VEND/CHANGE SHALL be rejected.
REQ-027 Selection in CREDIT accepted only if sel_id<N_DRINKS, credit>=price, stock>0; then credit -= price, ->VEND; otherwise ignored, stay CREDIT.
REQ-028 VEND SHALL assert drink_out bit sel_id for exactly one cycle, decrement that stock, ->CHANGE (accept at edge k: drink_out in cycle k+1, change_valid in k+2).
REQ-029 CHANGE SHALL drive change=credit, pulse change_valid (change may be 0), clear credit, ->IDLE.
REQ-030 cancel in CREDIT SHALL go to CHANGE with no drink; cancel in IDLE, VEND, CHANGE SHALL be ignored.
REQ-031 change SHALL hold 0 when change_valid low; drink_out SHALL be 0 outside VEND.

Reset
REQ-032 rst_n low, at any time including mid-VEND, SHALL force IDLE, credit=0, change=0, change_valid=0, drink_out=0, coin_reject=0, busy=0, stock=STOCK_INIT; credit is discarded without refund.

Configuration
REQ-033 Macro VEND_STOCK_EN defined: per-drink stock counters, sold_out, refill (IDLE only, ignored elsewhere) active.
REQ-034 VEND_STOCK_EN undefined: no stock counters, stock treated as infinite, sold_out tied 0, refill ignored.

Verification
REQ-035 coin 10, coin 5, sel_id=1 -> drink_out=4'b0010 one cycle, then change_valid with change=0, credit=0.
REQ-036 coin 20, coin 10, sel_id=0 -> drink_out=4'b0001, change=20.
REQ-037 credit 250, coin 10 -> coin_reject pulse, credit stays 250; sel_id=3 -> change=225.
REQ-038 coin 15, cancel -> change=15, drink_out never set; cancel+sel_valid same cycle -> refund only.
REQ-039 VEND_STOCK_EN: five vends of drink 3 -> sold_out[3]=1, sixth selection ignored; refill in IDLE -> sold_out[3]=0.
REQ-040 rst_n low during VEND -> drink_out=0, credit=0, state IDLE immediately.
